// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg: default parameter values and sizing helper shared by the
// stream_fifo top level and its storage array.
package stream_fifo_pkg;

   localparam int unsigned SF_DATA_WIDTH_DEF   = 16;
   localparam int unsigned SF_ADDR_WIDTH_DEF   = 5;
   localparam int unsigned SF_ALMOST_EMPTY_DEF = 2;

   // Number of entries addressed by an index of addr_width bits.
   function automatic int unsigned sf_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// stream_fifo_mem: DEPTH x DATA_WIDTH storage with synchronous write and
// asynchronous read so it maps onto distributed RAM. Contents are not reset.
module stream_fifo_mem
   import stream_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SF_DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = SF_ADDR_WIDTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   localparam int unsigned DEPTH = sf_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Store the accepted word at the tail index.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready FIFO with first-word-fall-through read data,
// registered occupancy and threshold flags.
// Optional feature: define STREAM_FIFO_WATERMARK_EN to add watermark_clear_i
// and watermark_o (peak occupancy since reset, flush or clear).
module stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH         = SF_DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH         = SF_ADDR_WIDTH_DEF,
   parameter int unsigned ALMOST_EMPTY_LEVEL = SF_ALMOST_EMPTY_DEF,
   parameter int unsigned ALMOST_FULL_LEVEL  = sf_depth(ADDR_WIDTH) - 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
`ifdef STREAM_FIFO_WATERMARK_EN
   input  logic                  watermark_clear_i,
   output logic [ADDR_WIDTH:0]   watermark_o,
`endif
   output logic [ADDR_WIDTH:0]   level_o,
   output logic                  empty_o,
   output logic                  almost_empty_o,
   output logic                  almost_full_o,
   output logic                  full_o
);

   localparam int unsigned DEPTH = sf_depth(ADDR_WIDTH);

   typedef logic [ADDR_WIDTH:0] level_t;

   localparam level_t LVL_ONE  = level_t'(1);
   localparam level_t LVL_FULL = level_t'(DEPTH);
   localparam level_t LVL_AE   = level_t'(ALMOST_EMPTY_LEVEL);
   localparam level_t LVL_AF   = level_t'(ALMOST_FULL_LEVEL);

   // Pointers carry one extra bit so a full buffer and an empty one differ.
   level_t wr_ptr_q, wr_ptr_d;
   level_t rd_ptr_q, rd_ptr_d;
   level_t level_q,  level_d;
   logic   empty_q,  empty_d;
   logic   aempty_q, aempty_d;
   logic   afull_q,  afull_d;
   logic   full_q,   full_d;

   logic                  wr_fire;
   logic                  rd_fire;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Fires depend only on registered flags, so no input reaches an output.
   assign wr_fire = wr_valid_i & ~full_q;
   assign rd_fire = rd_ready_i & ~empty_q;

   // Next pointers; occupancy is their modular difference, flags follow it.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_fire) wr_ptr_d = wr_ptr_q + LVL_ONE;
         if (rd_fire) rd_ptr_d = rd_ptr_q + LVL_ONE;
      end
      level_d  = wr_ptr_d - rd_ptr_d;
      empty_d  = (level_d == '0);
      full_d   = (level_d == LVL_FULL);
      aempty_d = (level_d <= LVL_AE);
      afull_d  = (level_d >= LVL_AF);
   end

   // Pointer, level and flag registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         empty_q  <= 1'b1;
         aempty_q <= 1'b1;
         afull_q  <= 1'b0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         empty_q  <= empty_d;
         aempty_q <= aempty_d;
         afull_q  <= afull_d;
         full_q   <= full_d;
      end
   end

   // A write presented alongside flush is dropped rather than stored.
   stream_fifo_mem #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_mem (
      .clk_i    (clk_i),
      .wr_en_i  (wr_fire & ~flush_i),
      .wr_addr_i(wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data_i(wr_data_i),
      .rd_addr_i(rd_ptr_q[ADDR_WIDTH-1:0]),
      .rd_data_o(mem_rdata)
   );

   assign wr_ready_o     = ~full_q;
   assign rd_valid_o     = ~empty_q;
   assign rd_data_o      = empty_q ? '0 : mem_rdata;
   assign level_o        = level_q;
   assign empty_o        = empty_q;
   assign almost_empty_o = aempty_q;
   assign almost_full_o  = afull_q;
   assign full_o         = full_q;

`ifdef STREAM_FIFO_WATERMARK_EN
   level_t wm_q, wm_d;

   // Track the peak registered level; flush or clear restart from level_next.
   always_comb begin
      wm_d = wm_q;
      if (flush_i || watermark_clear_i) begin
         wm_d = level_d;
      end else if (level_q > wm_q) begin
         wm_d = level_q;
      end
   end

   // Watermark register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wm_q <= '0;
      end else begin
         wm_q <= wm_d;
      end
   end

   assign watermark_o = wm_q;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: table-driven, hand-written and randomized checks of
// stream_fifo against a queue-based reference model.
module tb_stream_fifo;

   localparam int DW     = 16;
   localparam int AW     = 3;
   localparam int DEPTH  = 8;
   localparam int AE_LVL = 2;
   localparam int AF_LVL = DEPTH - 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [DW-1:0] wd;
   logic          wv;
   logic          wr_ready;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rr;
   logic [AW:0]   level;
   logic          empty, aempty, afull, full;
`ifdef STREAM_FIFO_WATERMARK_EN
   logic          wm_clr;
   logic [AW:0]   wm_o;
`endif

   always #5 clk = ~clk;

   stream_fifo #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .flush_i       (flush),
      .wr_data_i     (wd),
      .wr_valid_i    (wv),
      .wr_ready_o    (wr_ready),
      .rd_data_o     (rd_data),
      .rd_valid_o    (rd_valid),
      .rd_ready_i    (rr),
`ifdef STREAM_FIFO_WATERMARK_EN
      .watermark_clear_i(wm_clr),
      .watermark_o   (wm_o),
`endif
      .level_o       (level),
      .empty_o       (empty),
      .almost_empty_o(aempty),
      .almost_full_o (afull),
      .full_o        (full)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: contents as a queue, peak tracker as an integer.
   logic [DW-1:0] mq[$];
   int            wm_m = 0;

   typedef struct {
      bit            wv;
      logic [DW-1:0] wd;
      bit            rr;
      bit            fl;
      int            lvl;
      logic [DW-1:0] data;
      bit            empty;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic check_all(input string tag);
      int lvl;
      lvl = mq.size();
      chk({tag, " level"},    int'(level),    lvl);
      chk({tag, " empty"},    int'(empty),    int'(lvl == 0));
      chk({tag, " full"},     int'(full),     int'(lvl == DEPTH));
      chk({tag, " aempty"},   int'(aempty),   int'(lvl <= AE_LVL));
      chk({tag, " afull"},    int'(afull),    int'(lvl >= AF_LVL));
      chk({tag, " wr_ready"}, int'(wr_ready), int'(lvl < DEPTH));
      chk({tag, " rd_valid"}, int'(rd_valid), int'(lvl > 0));
      chk({tag, " rd_data"},  int'(rd_data),  (lvl > 0) ? int'(mq[0]) : 0);
`ifdef STREAM_FIFO_WATERMARK_EN
      chk({tag, " watermark"}, int'(wm_o), wm_m);
`endif
   endtask

   // One clock: drive inputs, advance model by the spec's fire rules, check.
   task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r,
                        input bit f, input bit c, input string tag);
      bit wf, rf;
      int prev;
      wv = v; wd = d; rr = r; flush = f;
`ifdef STREAM_FIFO_WATERMARK_EN
      wm_clr = c;
`endif
      prev = mq.size();
      wf = v && (prev < DEPTH);
      rf = r && (prev > 0);
      @(posedge clk);
      #1;
      if (f) begin
         mq.delete();
      end else begin
         if (rf) void'(mq.pop_front());
         if (wf) mq.push_back(d);
      end
      if (f || c) wm_m = mq.size();
      else if (prev > wm_m) wm_m = prev;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; wv = 1'b0; rr = 1'b0; wd = '0;
`ifdef STREAM_FIFO_WATERMARK_EN
      wm_clr = 1'b0;
`endif
      //                wv  wd        rr fl lvl data      empty
      tbl[0] = '{1'b1, 16'h1111, 1'b0, 1'b0, 1, 16'h1111, 1'b0};
      tbl[1] = '{1'b1, 16'h2222, 1'b0, 1'b0, 2, 16'h1111, 1'b0};
      tbl[2] = '{1'b1, 16'h3333, 1'b0, 1'b0, 3, 16'h1111, 1'b0};
      tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2, 16'h2222, 1'b0};
      tbl[4] = '{1'b1, 16'h4444, 1'b1, 1'b0, 2, 16'h3333, 1'b0};
      tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h4444, 1'b0};
      tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b1};
      tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b1};
      tbl[8] = '{1'b1, 16'h5555, 1'b0, 1'b1, 0, 16'h0000, 1'b1};
      tbl[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 1'b1};

      #2;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Table-driven basic traffic, empty-read and flushed write.
      for (int i = 0; i < 10; i++) begin
         cycle(tbl[i].wv, tbl[i].wd, tbl[i].rr, tbl[i].fl, 1'b0, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d tbl_level", i), int'(level),   tbl[i].lvl);
         chk($sformatf("vec%0d tbl_data", i),  int'(rd_data), int'(tbl[i].data));
         chk($sformatf("vec%0d tbl_empty", i), int'(empty),   int'(tbl[i].empty));
      end

      // Fill to full, refused write alongside a read, then accepted write.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'(16'hA000 + i), 1'b0, 1'b0, 1'b0, "fill");
      chk("full_flag", int'(full), 1);
      chk("full_level", int'(level), DEPTH);
      chk("full_wr_ready", int'(wr_ready), 0);
      cycle(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, "full_rw");
      chk("full_refused_level", int'(level), DEPTH - 1);
      chk("full_refused_head", int'(rd_data), 16'hA001);
      cycle(1'b1, 16'hC0DE, 1'b0, 1'b0, 1'b0, "full_accept");
      chk("full_accept_level", int'(level), DEPTH);
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, "drain");
      chk("drain_empty", int'(empty), 1);

      // Sustained simultaneous traffic across many pointer wraps.
      for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'hD000 + i), 1'b0, 1'b0, 1'b0, "prefill");
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0, "stream");
         chk($sformatf("stream%0d level_const", i), int'(level), 3);
      end

      // Flush with a concurrent write: contents and the write both vanish.
      cycle(1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b0, "flush");
      chk("flush_level", int'(level), 0);
      chk("flush_data", int'(rd_data), 0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, "post_flush");
      chk("post_flush_empty", int'(empty), 1);

      // Asynchronous reset between edges with two words held.
      cycle(1'b1, 16'h7001, 1'b0, 1'b0, 1'b0, "pre_rst");
      cycle(1'b1, 16'h7002, 1'b0, 1'b0, 1'b0, "pre_rst");
      wv = 1'b0; rr = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      mq.delete();
      wm_m = 0;
      check_all("arst_imm");
      chk("arst_imm rd_valid", int'(rd_valid), 0);
      @(posedge clk);
      #1;
      check_all("arst_hold");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all("arst_release");

`ifdef STREAM_FIFO_WATERMARK_EN
      for (int i = 0; i < 6; i++) cycle(1'b1, 16'(16'hE000 + i), 1'b0, 1'b0, 1'b0, "wm_fill");
      for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, "wm_drain");
      chk("wm_peak", int'(wm_o), 6);
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, "wm_clear");
      chk("wm_cleared", int'(wm_o), 1);
`endif

      // Randomized traffic with alternating write-heavy and read-heavy phases.
      for (int i = 0; i < 600; i++) begin
         bit v, r, f, c;
         if ((i / 50) % 2 == 0) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            v = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
         end
         f = ($urandom_range(0, 63) == 0);
         c = ($urandom_range(0, 31) == 0);
         cycle(v, 16'($urandom), r, f, c, $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
